// File: rtl/breath_led_multi.sv
// Multi-channel breathing-LED driver: a 3-stage timebase sweeps one triangular PWM
// duty ramp, and each channel selects off / on / breathe / anti-phase breathe.
module breath_led_multi #(
    parameter int CH_NUM      = 4,
    parameter int DELAY_2US   = 100,
    parameter int DELAY_2MS   = 1000,
    parameter int DELAY_2S    = 1000,
    parameter bit LED_ACT_LOW = 1'b0
) (
    input  logic                  sclk,
    input  logic                  s_rst_n,
    input  logic                  en,
    input  logic [2*CH_NUM-1:0]   mode,
    output logic [CH_NUM-1:0]     led,
    output logic                  dir,
    output logic                  period_done
);

    localparam int W_US = (DELAY_2US > 1) ? $clog2(DELAY_2US) : 1;
    localparam int W_MS = (DELAY_2MS > 1) ? $clog2(DELAY_2MS) : 1;
    localparam int W_S  = (DELAY_2S  > 1) ? $clog2(DELAY_2S)  : 1;

    localparam logic [W_US-1:0] US_MAX    = W_US'(DELAY_2US - 1);
    localparam logic [W_MS-1:0] MS_MAX    = W_MS'(DELAY_2MS - 1);
    localparam logic [W_S-1:0]  S_MAX     = W_S'(DELAY_2S - 1);
    // Ramp level is compared against the PWM counter, so it lives in that width.
    localparam logic [W_MS-1:0] LVL_MAX   = W_MS'(DELAY_2S - 1);
    localparam logic [CH_NUM-1:0] OFF_LVL = {CH_NUM{LED_ACT_LOW}};

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BREATHE = 2'b10,
        MODE_ANTI    = 2'b11
    } mode_e;

    logic [W_US-1:0]   r_cnt_us;
    logic [W_MS-1:0]   r_cnt_ms;
    logic [W_S-1:0]    r_cnt_s;
    logic              r_dir;
    logic [CH_NUM-1:0] r_led;
    logic              r_period_done;

    logic              w_tick_us;
    logic              w_tick_ms;
    logic              w_wrap_s;
    logic [W_MS-1:0]   w_lvl;
    logic [W_MS-1:0]   w_ilvl;
    logic              w_breathe_on;
    logic              w_anti_on;
    logic [CH_NUM-1:0] w_sel;

    assign w_tick_us = (r_cnt_us == US_MAX);
    assign w_tick_ms = w_tick_us && (r_cnt_ms == MS_MAX);
    assign w_wrap_s  = w_tick_ms && (r_cnt_s == S_MAX);

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_cnt_us <= '0;
            r_cnt_ms <= '0;
            r_cnt_s  <= '0;
            r_dir    <= 1'b0;
        end else if (!en) begin
            r_cnt_us <= '0;
            r_cnt_ms <= '0;
            r_cnt_s  <= '0;
            r_dir    <= 1'b0;
        end else begin
            r_cnt_us <= w_tick_us ? '0 : r_cnt_us + 1'b1;
            if (w_tick_us) begin
                r_cnt_ms <= w_tick_ms ? '0 : r_cnt_ms + 1'b1;
            end
            if (w_tick_ms) begin
                r_cnt_s <= w_wrap_s ? '0 : r_cnt_s + 1'b1;
                if (w_wrap_s) begin
                    r_dir <= ~r_dir;
                end
            end
        end
    end

    assign w_lvl        = r_dir ? (LVL_MAX - W_MS'(r_cnt_s)) : W_MS'(r_cnt_s);
    assign w_ilvl       = LVL_MAX - w_lvl;
    assign w_breathe_on = (r_cnt_ms < w_lvl);
    assign w_anti_on    = (r_cnt_ms < w_ilvl);

    // NOTE: w_sel gets a default before the loop so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            case (mode_e'(mode[2*i +: 2]))
                MODE_OFF:     w_sel[i] = 1'b0;
                MODE_ON:      w_sel[i] = 1'b1;
                MODE_BREATHE: w_sel[i] = en & w_breathe_on;
                MODE_ANTI:    w_sel[i] = en & w_anti_on;
            endcase
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_led         <= OFF_LVL;
            r_period_done <= 1'b0;
        end else begin
            r_led         <= OFF_LVL ^ w_sel;
            r_period_done <= en & w_wrap_s & r_dir;
        end
    end

    assign led         = r_led;
    assign dir         = r_dir;
    assign period_done = r_period_done;

endmodule
